fft_frame_sequencer: RTL

Top-level frame controller for the FFT datapath. It steps each frame through load, compute and unload phases. In each phase it hands the shared sample memory to exactly one owner: the input side of the I/O block, the FFT core, or the output side of the I/O block. It drives the `fft_busy`/`fft_valid` handshake into the I/O block and the start/abort handshake into the FFT core. It also guards the compute phase with a watchdog and keeps a frame counter.

---
 rtl/fft_frame_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame controller stepping FFT frames through load, compute and unload
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   en                permits a new frame to start (IDLE->LOAD, UNLOAD->LOAD)
//   in_frame_done     pulse: input side finished writing N samples
//   core_done         pulse: FFT core finished the transform
//   out_frame_done    pulse: output side finished reading N results
//   core_start        pulse: start the FFT core (first COMPUTE cycle)
//   core_abort        pulse: watchdog expired in COMPUTE
//   fft_busy          high while in COMPUTE
//   fft_valid         high while in UNLOAD
//   mem_owner         sample memory select: 0 none, 1 input, 2 core, 3 output
//   state_o           current state (debug)
//   frame_count       completed frames, wraps
//   timeout_err       sticky watchdog error, cleared only by reset
module fft_frame_sequencer #(
  parameter int N         = 32,
  parameter int TIMEOUT   = 1024,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_frame_done,
  input  logic                 core_done,
  input  logic                 out_frame_done,
  output logic                 core_start,
  output logic                 core_abort,
  output logic                 fft_busy,
  output logic                 fft_valid,
  output logic [1:0]           mem_owner,
  output logic [1:0]           state_o,
  output logic [cnt_width-1:0] frame_count,
  output logic                 timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  // An illegal point count never lets a frame start.
  localparam logic N_OK = (N >= 4) && ((N & (N - 1)) == 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 core_start_q, core_start_d;
  logic                 core_abort_q, core_abort_d;
  logic                 fft_busy_q, fft_busy_d;
  logic                 fft_valid_q, fft_valid_d;
  logic [1:0]           mem_owner_q, mem_owner_d;
  logic [cnt_width-1:0] frame_count_q, frame_count_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 start_ok;

  assign start_ok = en && N_OK;

  always_comb begin
    state_d       = state_q;
    core_start_d  = 1'b0;
    core_abort_d  = 1'b0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (in_frame_done) begin
          state_d      = S_COMPUTE;
          core_start_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        // core_done wins over a watchdog expiry in the same cycle.
        if (core_done) begin
          state_d = S_UNLOAD;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d       = S_IDLE;
          core_abort_d  = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_frame_done) begin
          frame_count_d = frame_count_q + 1'b1;
          state_d       = start_ok ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Zero on every COMPUTE entry because the previous state is never COMPUTE.
    wd_d = (state_q == S_COMPUTE) ? wd_q + 1'b1 : '0;

    // Moore outputs decoded from the state being entered so they move with it.
    fft_busy_d  = (state_d == S_COMPUTE);
    fft_valid_d = (state_d == S_UNLOAD);
    case (state_d)
      S_LOAD:    mem_owner_d = 2'd1;
      S_COMPUTE: mem_owner_d = 2'd2;
      S_UNLOAD:  mem_owner_d = 2'd3;
      default:   mem_owner_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      core_start_q  <= 1'b0;
      core_abort_q  <= 1'b0;
      fft_busy_q    <= 1'b0;
      fft_valid_q   <= 1'b0;
      mem_owner_q   <= 2'd0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      core_start_q  <= core_start_d;
      core_abort_q  <= core_abort_d;
      fft_busy_q    <= fft_busy_d;
      fft_valid_q   <= fft_valid_d;
      mem_owner_q   <= mem_owner_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_abort  = core_abort_q;
  assign fft_busy    = fft_busy_q;
  assign fft_valid   = fft_valid_q;
  assign mem_owner   = mem_owner_q;
  assign state_o     = state_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;

endmodule
